// File: rtl/mem_sub_unit_requester.sv
// Issues LSU load/store requests to one memory sub unit and returns aligned, extended load results in order.
// Optional MEM_REQ_MISALIGN_TRAP_EN rejects misaligned half/word requests; otherwise low address bits are cleared.
module mem_sub_unit_requester #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ID_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_addr,
    input  logic            req_load,
    input  logic            req_store,
    input  logic [1:0]      req_size,
    input  logic            req_signed,
    input  logic [31:0]     req_wdata,
    input  logic [ID_W-1:0] req_id,
    output logic            sub_new_request,
    output logic [31:0]     sub_addr,
    output logic            sub_re,
    output logic            sub_we,
    output logic [3:0]      sub_be,
    output logic [31:0]     sub_data_in,
    input  logic            sub_ready,
    input  logic            sub_data_valid,
    input  logic [31:0]     sub_data_out,
    output logic            rsp_valid,
    output logic [31:0]     rsp_data,
    output logic [ID_W-1:0] rsp_id,
    output logic            err_unexpected,
    output logic            misaligned_err
);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      size;
        logic            sgn;
        logic [1:0]      off;
    } entry_t;

    entry_t           fifo_mem [MAX_OUTSTANDING];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             accept, rejected, push, pop;
    logic [1:0]       size_eff;
    logic [31:0]      addr_eff;
    logic [31:0]      shifted, rsp_next;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Size code 3 behaves exactly like a word everywhere, including the stored entry.
    assign size_eff = (req_size == 2'd3) ? 2'd2 : req_size;

`ifdef MEM_REQ_MISALIGN_TRAP_EN
    assign rejected = ((size_eff == 2'd1) && req_addr[0]) ||
                      ((size_eff == 2'd2) && (req_addr[1:0] != 2'b00));
    assign addr_eff = req_addr;
`else
    assign rejected = 1'b0;
    always_comb begin
        addr_eff = req_addr;
        if (size_eff == 2'd1)
            addr_eff[0] = 1'b0;
        else if (size_eff == 2'd2)
            addr_eff[1:0] = 2'b00;
    end
`endif

    // A pop in this cycle frees a slot, so a load may still be taken when full.
    assign req_ready       = sub_ready && (req_store || (count < CNT_MAX) || sub_data_valid);
    assign accept          = req_valid && req_ready;
    assign sub_new_request = accept && !rejected;
    assign push            = sub_new_request && req_load;
    assign pop             = sub_data_valid && (count != '0);

    assign sub_addr = addr_eff;
    assign sub_re   = req_load;
    assign sub_we   = req_store;

    always_comb begin
        sub_be      = 4'b0000;
        sub_data_in = req_wdata;
        case (size_eff)
            2'd0:    sub_data_in = {4{req_wdata[7:0]}};
            2'd1:    sub_data_in = {2{req_wdata[15:0]}};
            default: sub_data_in = req_wdata;
        endcase
        if (req_store) begin
            case (size_eff)
                2'd0:    sub_be = 4'b0001 << addr_eff[1:0];
                2'd1:    sub_be = addr_eff[1] ? 4'b1100 : 4'b0011;
                default: sub_be = 4'b1111;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= '{id: req_id, size: size_eff, sgn: req_signed, off: addr_eff[1:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    assign head    = fifo_mem[rd_ptr];
    assign shifted = sub_data_out >> {head.off, 3'b000};

    always_comb begin
        case (head.size)
            2'd0:    rsp_next = {{24{head.sgn & shifted[7]}}, shifted[7:0]};
            2'd1:    rsp_next = {{16{head.sgn & shifted[15]}}, shifted[15:0]};
            default: rsp_next = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_id         <= '0;
            err_unexpected <= 1'b0;
        end else begin
            rsp_valid <= pop;
            if (pop) begin
                rsp_data <= rsp_next;
                rsp_id   <= head.id;
            end
            if (sub_data_valid && (count == '0))
                err_unexpected <= 1'b1;
        end
    end

`ifdef MEM_REQ_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst)
            misaligned_err <= 1'b0;
        else
            misaligned_err <= accept && rejected;
    end
`else
    assign misaligned_err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_sub_unit_requester.sv
// Directed bench for mem_sub_unit_requester with a response scoreboard checked by an independent monitor.
module tb_mem_sub_unit_requester;
    logic        clk, rst;
    logic        req_valid, req_ready, req_load, req_store, req_signed;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic [2:0]  req_id;
    logic        sub_new_request, sub_re, sub_we, sub_ready, sub_data_valid;
    logic [31:0] sub_addr, sub_data_in, sub_data_out;
    logic [3:0]  sub_be;
    logic        rsp_valid, err_unexpected, misaligned_err;
    logic [31:0] rsp_data;
    logic [2:0]  rsp_id;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  id;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;

    mem_sub_unit_requester #(.MAX_OUTSTANDING(2), .ID_W(3)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_load(req_load), .req_store(req_store), .req_size(req_size),
        .req_signed(req_signed), .req_wdata(req_wdata), .req_id(req_id),
        .sub_new_request(sub_new_request), .sub_addr(sub_addr), .sub_re(sub_re),
        .sub_we(sub_we), .sub_be(sub_be), .sub_data_in(sub_data_in),
        .sub_ready(sub_ready), .sub_data_valid(sub_data_valid), .sub_data_out(sub_data_out),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .err_unexpected(err_unexpected), .misaligned_err(misaligned_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid      = 1'b0;
        req_load       = 1'b0;
        req_store      = 1'b0;
        req_signed     = 1'b0;
        req_size       = 2'd0;
        req_addr       = '0;
        req_wdata      = '0;
        req_id         = '0;
        sub_data_valid = 1'b0;
        sub_data_out   = '0;
    endtask

    task automatic set_req(input logic ld, input logic [31:0] a, input logic [1:0] sz,
                           input logic sg, input logic [31:0] wd, input logic [2:0] id);
        req_valid  = 1'b1;
        req_load   = ld;
        req_store  = !ld;
        req_addr   = a;
        req_size   = sz;
        req_signed = sg;
        req_wdata  = wd;
        req_id     = id;
    endtask

    task automatic ret(input logic [31:0] d);
        sub_data_valid = 1'b1;
        sub_data_out   = d;
    endtask

    // Monitor: every response must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: got data 0x%08h id %0d, none expected", rsp_data, rsp_id);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (rsp_data !== e.data || rsp_id !== e.id) begin
                    bad++;
                    $display("FAIL rsp: got data 0x%08h id %0d expected data 0x%08h id %0d",
                             rsp_data, rsp_id, e.data, e.id);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        sub_ready = 1'b0;
        idle();
        repeat (3) tick();
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_id", {29'b0, rsp_id}, 32'd0);
        chk("rst_err", {31'b0, err_unexpected}, 32'd0);
        chk("rst_misalign", {31'b0, misaligned_err}, 32'd0);
        rst = 1'b0;

        // Stores: byte, half, word
        tick();
        sub_ready = 1'b1;
        set_req(1'b0, 32'h0000_1002, 2'd0, 1'b0, 32'h0000_00A5, 3'd0);
        #1;
        chk("stb_new", {31'b0, sub_new_request}, 32'd1);
        chk("stb_we", {31'b0, sub_we}, 32'd1);
        chk("stb_re", {31'b0, sub_re}, 32'd0);
        chk("stb_be", {28'b0, sub_be}, 32'h4);
        chk("stb_data", sub_data_in, 32'hA5A5_A5A5);
        chk("stb_addr", sub_addr, 32'h0000_1002);
        tick();
        set_req(1'b0, 32'h0000_1006, 2'd1, 1'b0, 32'h0000_BEEF, 3'd0);
        #1;
        chk("sth_be", {28'b0, sub_be}, 32'hC);
        chk("sth_data", sub_data_in, 32'hBEEF_BEEF);
        tick();
        set_req(1'b0, 32'h0000_1008, 2'd2, 1'b0, 32'h0123_4567, 3'd0);
        #1;
        chk("stw_be", {28'b0, sub_be}, 32'hF);
        chk("stw_data", sub_data_in, 32'h0123_4567);

        // Signed half load, two-cycle latency to response
        tick();
        set_req(1'b1, 32'h0000_2002, 2'd1, 1'b1, 32'h0, 3'd5);
        #1;
        chk("ldh_new", {31'b0, sub_new_request}, 32'd1);
        chk("ldh_be", {28'b0, sub_be}, 32'h0);
        chk("ldh_re", {31'b0, sub_re}, 32'd1);
        sbq.push_back('{data: 32'hFFFF_8001, id: 3'd5});
        tick();
        idle();
        ret(32'h8001_7FFF);
        tick();
        idle();
        chk("ldh_latency", {31'b0, rsp_valid}, 32'd1);

        // Two loads fill the tracker; third stalls until the first return
        tick();
        set_req(1'b1, 32'h0000_0010, 2'd0, 1'b0, 32'h0, 3'd1);
        sbq.push_back('{data: 32'h0000_0011, id: 3'd1});
        tick();
        set_req(1'b1, 32'h0000_0014, 2'd0, 1'b0, 32'h0, 3'd2);
        sbq.push_back('{data: 32'h0000_0022, id: 3'd2});
        tick();
        set_req(1'b1, 32'h0000_001B, 2'd0, 1'b1, 32'h0, 3'd3);
        #1;
        chk("full_ready", {31'b0, req_ready}, 32'd0);
        chk("full_new", {31'b0, sub_new_request}, 32'd0);
        tick();
        ret(32'h0000_0011);
        #1;
        chk("pop_ready", {31'b0, req_ready}, 32'd1);
        chk("pop_new", {31'b0, sub_new_request}, 32'd1);
        sbq.push_back('{data: 32'hFFFF_FF83, id: 3'd3});
        tick();
        idle();
        ret(32'h0000_0022);
        tick();
        ret(32'h8300_0000);
        tick();
        idle();

        // Sub unit not ready holds the request
        set_req(1'b1, 32'h0000_0040, 2'd2, 1'b0, 32'h0, 3'd4);
        sub_ready = 1'b0;
        #1;
        chk("nrdy_ready", {31'b0, req_ready}, 32'd0);
        chk("nrdy_new", {31'b0, sub_new_request}, 32'd0);
        tick();
        sub_ready = 1'b1;
        #1;
        chk("rdy_ready", {31'b0, req_ready}, 32'd1);
        chk("rdy_new", {31'b0, sub_new_request}, 32'd1);
        sbq.push_back('{data: 32'hDEAD_BEEF, id: 3'd4});
        tick();
        idle();
        ret(32'hDEAD_BEEF);
        tick();
        idle();

        // Misaligned word load
        set_req(1'b1, 32'h0000_3001, 2'd2, 1'b0, 32'h0, 3'd6);
        #1;
`ifdef MEM_REQ_MISALIGN_TRAP_EN
        chk("mis_ready", {31'b0, req_ready}, 32'd1);
        chk("mis_new", {31'b0, sub_new_request}, 32'd0);
        tick();
        idle();
        chk("mis_pulse", {31'b0, misaligned_err}, 32'd1);
        tick();
        chk("mis_pulse_end", {31'b0, misaligned_err}, 32'd0);
`else
        chk("mis_addr", sub_addr, 32'h0000_3000);
        chk("mis_new", {31'b0, sub_new_request}, 32'd1);
        sbq.push_back('{data: 32'hCAFE_F00D, id: 3'd6});
        tick();
        idle();
        chk("mis_tied", {31'b0, misaligned_err}, 32'd0);
        ret(32'hCAFE_F00D);
        tick();
        idle();
`endif

        // Return with nothing outstanding
        tick();
        chk("err_before", {31'b0, err_unexpected}, 32'd0);
        ret(32'h0000_0055);
        tick();
        idle();
        chk("err_set", {31'b0, err_unexpected}, 32'd1);
        repeat (3) tick();
        chk("err_sticky", {31'b0, err_unexpected}, 32'd1);

        // Reset mid-operation drops the outstanding load
        set_req(1'b1, 32'h0000_0000, 2'd0, 1'b0, 32'h0, 3'd7);
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("err_cleared", {31'b0, err_unexpected}, 32'd0);
        ret(32'h0000_0077);
        tick();
        idle();
        chk("rst_flush_err", {31'b0, err_unexpected}, 32'd1);

        for (int i = 0; i < 20 && sbq.size() != 0; i++)
            tick();
        repeat (2) tick();
        chk("queue_drained", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
